// File: rtl/pos_delay_line_if.sv
// Bundle of the enable/sample inputs and the delayed/snapshot outputs of pos_delay_line.
// master drives samples and frame_sync; slave is the delay line itself.
interface pos_delay_line_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 12
);
  logic                      en;
  logic                      in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      frame_sync;
  logic                      out_valid;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS*WIDTH-1:0] frame_data;
  logic                      frame_valid;
  logic                      frame_stale;

  modport master (
    output en, in_valid, in_data, frame_sync,
    input  out_valid, out_data, frame_data, frame_valid, frame_stale
  );

  modport slave (
    input  en, in_valid, in_data, frame_sync,
    output out_valid, out_data, frame_data, frame_valid, frame_stale
  );
endinterface

// File: rtl/pos_delay_line.sv
// Delays CHANNELS coordinate words by DEPTH enabled cycles and keeps a frame_sync snapshot.
// Latency DEPTH enabled edges; en=0 freezes the pipeline, no backpressure beyond that.
module pos_delay_line #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 12,
  parameter int DEPTH    = 2
) (
  input logic            clk,
  input logic            rst_n,
  pos_delay_line_if.slave bus
);
  localparam int BW = CHANNELS * WIDTH;

  logic [BW-1:0]    stage_data [DEPTH];
  logic [DEPTH-1:0] stage_vld;
  logic             last_load;
  logic             new_since_sync;
  logic             seen_valid;
  logic [BW-1:0]    frame_data_q;
  logic             frame_valid_q;
  logic             frame_stale_q;

  // Valid bit that the next enabled shift will place into the last stage.
  generate
    if (DEPTH == 1) begin : g_single
      assign last_load = bus.en & bus.in_valid;
    end else begin : g_multi
      assign last_load = bus.en & stage_vld[DEPTH-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_data[k] <= '0;
      end
      stage_vld <= '0;
    end else if (bus.en) begin
      if (bus.in_valid) begin
        stage_data[0] <= bus.in_data;
      end
      stage_vld[0] <= bus.in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        stage_data[k] <= stage_data[k-1];
        stage_vld[k]  <= stage_vld[k-1];
      end
    end
  end

  // Snapshot uses pre-edge values, so a shift on the same edge never leaks in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      new_since_sync <= 1'b0;
      seen_valid     <= 1'b0;
      frame_data_q   <= '0;
      frame_valid_q  <= 1'b0;
      frame_stale_q  <= 1'b1;
    end else begin
      seen_valid <= seen_valid | stage_vld[DEPTH-1];
      if (last_load) begin
        new_since_sync <= 1'b1;
      end else if (bus.frame_sync) begin
        new_since_sync <= 1'b0;
      end
      if (bus.frame_sync) begin
        frame_data_q  <= stage_data[DEPTH-1];
        frame_stale_q <= ~new_since_sync;
        frame_valid_q <= frame_valid_q | stage_vld[DEPTH-1] | seen_valid;
      end
    end
  end

  assign bus.out_valid   = stage_vld[DEPTH-1];
  assign bus.out_data    = stage_data[DEPTH-1];
  assign bus.frame_data  = frame_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_stale = frame_stale_q;
endmodule

// File: tb/tb_pos_delay_line.sv
// Drives a DEPTH=2 and a DEPTH=4 delay line with the same stimulus; a monitor checks both
// against a sample-history reference model through per-instance expectation queues.
module tb_pos_delay_line;
  localparam int BW   = 48;
  localparam int HMAX = 8192;

  typedef struct packed {
    logic          ov;
    logic [BW-1:0] od;
    logic [BW-1:0] fd;
    logic          fv;
    logic          fs;
  } rec_t;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          in_valid;
  logic [BW-1:0] in_data;
  logic          frame_sync;
  logic          done;

  int checks;
  int fails;
  int cycle;

  pos_delay_line_if #(.CHANNELS(4), .WIDTH(12)) if_a ();
  pos_delay_line_if #(.CHANNELS(4), .WIDTH(12)) if_b ();

  assign if_a.en = en;
  assign if_a.in_valid = in_valid;
  assign if_a.in_data = in_data;
  assign if_a.frame_sync = frame_sync;
  assign if_b.en = en;
  assign if_b.in_valid = in_valid;
  assign if_b.in_data = in_data;
  assign if_b.frame_sync = frame_sync;

  pos_delay_line #(.CHANNELS(4), .WIDTH(12), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );
  pos_delay_line #(.CHANNELS(4), .WIDTH(12), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the output is simply the sample accepted DEPTH enabled edges ago.
  logic          hv [2][HMAX];
  logic [BW-1:0] hd [2][HMAX];
  int            n  [2];
  logic [BW-1:0] last_d [2];
  logic          ns [2];
  logic          sv [2];
  logic          fv [2];
  logic          fs [2];
  logic [BW-1:0] fd [2];
  rec_t          exp_q0 [$];
  rec_t          exp_q1 [$];

  function automatic int depth_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic logic m_ov(input int i);
    int dp = depth_of(i);
    return (n[i] >= dp) ? hv[i][n[i]-dp] : 1'b0;
  endfunction

  function automatic logic [BW-1:0] m_od(input int i);
    int dp = depth_of(i);
    return (n[i] >= dp) ? hd[i][n[i]-dp] : '0;
  endfunction

  function automatic logic [BW-1:0] mk(input int k);
    return {12'(k + 'h300), 12'(k + 'h200), 12'(k + 'h100), 12'(k)};
  endfunction

  task automatic model_edge(input int i);
    logic          pov;
    logic [BW-1:0] pod;
    logic          pns;
    logic          psv;
    rec_t          r;
    if (!rst_n) begin
      n[i] = 0; last_d[i] = '0; ns[i] = 1'b0; sv[i] = 1'b0;
      fv[i] = 1'b0; fs[i] = 1'b1; fd[i] = '0;
    end else begin
      pov = m_ov(i); pod = m_od(i); pns = ns[i]; psv = sv[i];
      if (en && n[i] < HMAX) begin
        if (in_valid) last_d[i] = in_data;
        hv[i][n[i]] = in_valid;
        hd[i][n[i]] = last_d[i];
        n[i]++;
      end
      sv[i] = psv | pov;
      if (en && m_ov(i)) ns[i] = 1'b1;
      else if (frame_sync) ns[i] = 1'b0;
      if (frame_sync) begin
        fd[i] = pod;
        fs[i] = ~pns;
        fv[i] = fv[i] | pov | psv;
      end
    end
    r.ov = m_ov(i); r.od = m_od(i); r.fd = fd[i]; r.fv = fv[i]; r.fs = fs[i];
    if (i == 0) exp_q0.push_back(r);
    else exp_q1.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    cycle++;
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
  endtask

  task automatic cyc(input logic r, input logic e, input logic v,
                     input logic [BW-1:0] d, input logic f);
    rst_n = r; en = e; in_valid = v; in_data = d; frame_sync = f;
    step();
  endtask

  task automatic check(input int id, input rec_t want, input rec_t got);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL dut%0d_cycle%0d: got ov=%0b od=%h fd=%h fv=%0b fs=%0b, want ov=%0b od=%h fd=%h fv=%0b fs=%0b",
               id, cycle, got.ov, got.od, got.fd, got.fv, got.fs,
               want.ov, want.od, want.fd, want.fv, want.fs);
    end
  endtask

  // Monitor: pops one expectation per instance each cycle and compares.
  initial begin
    rec_t want;
    rec_t got;
    forever begin
      @(negedge clk);
      if (exp_q0.size() > 0) begin
        want = exp_q0.pop_front();
        got  = {if_a.out_valid, if_a.out_data, if_a.frame_data, if_a.frame_valid, if_a.frame_stale};
        check(0, want, got);
      end
      if (exp_q1.size() > 0) begin
        want = exp_q1.pop_front();
        got  = {if_b.out_valid, if_b.out_data, if_b.frame_data, if_b.frame_valid, if_b.frame_stale};
        check(1, want, got);
      end
      if (done) begin
        checks++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
          fails++;
          $display("FAIL drain: %0d expectations left, want 0", exp_q0.size() + exp_q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [BW-1:0] cur;
    logic [11:0]   ch0;
    checks = 0; fails = 0; cycle = 0; done = 1'b0;
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; frame_sync = 1'b0;

    // Reset dominates en, in_valid and frame_sync.
    cyc(1'b0, 1'b1, 1'b1, {4{12'hFFF}}, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, {4{12'hFFF}}, 1'b1);

    // Single sample latency.
    cyc(1'b1, 1'b1, 1'b1, {12'hABC, 12'h000, 12'h000, 12'h123}, 1'b0);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Stall for five cycles with a sample in flight.
    cyc(1'b1, 1'b1, 1'b1, mk('h55), 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Stream 1,2,3,... and snapshot when the shorter line shows 7.
    for (int k = 1; k <= 20; k++) begin
      cur = m_od(0);
      ch0 = cur[11:0];
      cyc(1'b1, 1'b1, 1'b1, mk(k), m_ov(0) && ch0 == 12'd7);
    end
    repeat (10) cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Stale detection: two snapshots 100 cycles apart, then back-to-back pulses.
    cyc(1'b1, 1'b1, 1'b1, mk('h9A), 1'b0);
    repeat (9) cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);
    repeat (99) cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, mk('h61), 1'b1);
    cyc(1'b1, 1'b1, 1'b1, mk('h62), 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);

    // Reset mid-stream with both lines full.
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1'b1, mk('h70 + k), 1'b0);
    cyc(1'b0, 1'b1, 1'b1, mk('hEE), 1'b0);
    cyc(1'b1, 1'b1, 1'b1, mk('h42), 1'b0);
    repeat (6) cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Randomised traffic.
    for (int k = 0; k < 1500; k++) begin
      cyc($urandom_range(0, 99) != 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) < 6,
          {16'($urandom), 32'($urandom)},
          $urandom_range(0, 19) == 0);
    end
    repeat (3) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    done = 1'b1;
  end
endmodule
